// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Divide-by-zero result: quotient is all ones; the remainder is the low
  // DIVISOR_WIDTH bits of the raw dividend as presented with start.
  localparam logic DBZ_QUOTIENT_FILL = 1'b1;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_restoring_step #(
  parameter int M = 16
) (
  input  logic [M:0]   rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] divisor_i,
  output logic [M:0]   rem_o,
  output logic         q_o
);

  logic [M:0]   shifted;
  logic [M+1:0] diff;

  always_comb begin
    shifted = {rem_i[M-1:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    // A set top bit in the incoming remainder means the true shifted value
    // exceeds any M-bit divisor, so the subtraction cannot go negative.
    q_o     = rem_i[M] | ~diff[M+1];
    rem_o   = q_o ? diff[M:0] : shifted;
  end

endmodule

// File: rtl/divide_restoring_param.sv
// Iterative restoring divider: one quotient bit per clock, signed/unsigned per op.
module divide_restoring_param
  import div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16,
  parameter int COUNT_WIDTH    = $clog2(DIVIDEND_WIDTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      busy,
  output logic                      ready,
  output logic [COUNT_WIDTH-1:0]    count,
  output state_e                    state_dbg
);

  localparam int N = DIVIDEND_WIDTH;
  localparam int M = DIVISOR_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_ITER = COUNT_WIDTH'(N - 1);

  // Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
  // DONE); the accept edge drops ready and raises busy. ready rises with the
  // result and stays high, with results stable, until the next accept.

  state_e                 state_q, state_d;
  logic [N-1:0]           dvd_q, dvd_d;
  logic [M-1:0]           dvs_q, dvs_d;
  logic [M:0]             rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   dbz_pend_q, dbz_pend_d;
  logic [N-1:0]           quotient_q, quotient_d;
  logic [M-1:0]           remainder_q, remainder_d;
  logic                   dbz_q, dbz_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;

  logic [M:0]   step_rem;
  logic         step_bit;
  logic         dvd_neg;
  logic         dvs_neg;
  logic [N-1:0] dvd_mag;
  logic [M-1:0] dvs_mag;

  div_restoring_step #(.M(M)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[N-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_comb begin
    dvd_neg = signed_mode & dividend[N-1];
    dvs_neg = signed_mode & divisor[M-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    count_d     = count_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_pend_d  = dbz_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    ready_d     = ready_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !busy_q) begin
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          count_d   = '0;
          rem_d     = '0;
          dvs_d     = dvs_mag;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          // A zero divisor bypasses the iterations; the raw dividend is kept
          // so its low bits can be returned as the remainder.
          if (divisor == '0) begin
            dbz_pend_d = 1'b1;
            dvd_d      = dividend;
            state_d    = FIX;
          end else begin
            dbz_pend_d = 1'b0;
            dvd_d      = dvd_mag;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[N-2:0], step_bit};
        if (count_q == LAST_ITER) begin
          count_d = '0;
          state_d = FIX;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FIX: begin
        if (dbz_pend_q) begin
          quotient_d  = {N{DBZ_QUOTIENT_FILL}};
          remainder_d = dvd_q[M-1:0];
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
          remainder_d = neg_rem_q ? -rem_q[M-1:0] : rem_q[M-1:0];
          dbz_d       = 1'b0;
        end
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_pend_q  <= dbz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign count       = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_divide_restoring_param.sv
// Directed bench for divide_restoring_param at N=32, M=16.
module tb_divide_restoring_param;
  import div_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        busy;
  logic        ready;
  logic [4:0]  count;
  state_e      state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sm;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  divide_restoring_param #(
    .DIVIDEND_WIDTH(32),
    .DIVISOR_WIDTH (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .ready       (ready),
    .count       (count),
    .state_dbg   (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs are read at negedge, after the posedge.
  task automatic run_op(input logic sm, input logic [31:0] a, input logic [15:0] b,
                        output int edges);
    @(negedge clock);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    edges = 1;
    while (!ready && edges < 64) begin
      @(negedge clock);
      edges++;
    end
  endtask

  initial begin
    int edges;

    vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 16'h0002, 32'h7FFF_FFFF, 16'h0001, 1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 16'h0002, 32'hFFFF_FFFD, 16'hFFFF, 1'b0, 34};
    vecs[2]  = '{1'b1, 32'h0000_0007, 16'hFFFE, 32'hFFFF_FFFD, 16'h0001, 1'b0, 34};
    vecs[3]  = '{1'b0, 32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1, 2};
    vecs[4]  = '{1'b1, 32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1, 2};
    vecs[5]  = '{1'b0, 32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0, 34};
    vecs[6]  = '{1'b1, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 1'b0, 34};
    vecs[7]  = '{1'b0, 32'h8000_0000, 16'hFFFF, 32'h0000_8000, 16'h8000, 1'b0, 34};
    vecs[8]  = '{1'b0, 32'h0000_000A, 16'h000A, 32'h0000_0001, 16'h0000, 1'b0, 34};
    vecs[9]  = '{1'b0, 32'h0000_0005, 16'h0009, 32'h0000_0000, 16'h0005, 1'b0, 34};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9, 16'hFFFE, 32'h0000_0003, 16'hFFFF, 1'b0, 34};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 34};
    vecs[12] = '{1'b1, 32'h8000_0000, 16'h0001, 32'h8000_0000, 16'h0000, 1'b0, 34};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF, 16'h0000, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 2};

    // Reset state
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_by_zero, busy, ready}, 0);
    check("rst_count", count, 0);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sm, vecs[i].dvd, vecs[i].dvs, edges);
      check($sformatf("v%0d_latency", i), edges, vecs[i].lat);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      check($sformatf("v%0d_busy_ready", i), {busy, ready}, 2'b01);
      repeat (2) @(negedge clock);
      check($sformatf("v%0d_hold", i), {quotient, remainder, ready}, {vecs[i].q, vecs[i].r, 1'b1});
    end

    // Count steps 0..31 through RUN, then FIX, then result at edge 34
    @(negedge clock);
    signed_mode = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 16'h0002; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("a_accept", {busy, ready}, 2'b10);
    check("a_state_run", state_dbg, RUN);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("a_count_%0d", k), count, k);
      @(negedge clock);
    end
    check("a_fix_count", count, 0);
    check("a_fix_state", state_dbg, FIX);
    @(negedge clock);
    check("a_result", {quotient, remainder, busy, ready}, {32'h7FFF_FFFF, 16'h0001, 2'b01});

    // start while busy is ignored
    @(negedge clock);
    signed_mode = 1'b0; dividend = 32'h0000_0064; divisor = 16'h0007; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    edges = 1;
    while (count != 5 && edges < 64) begin
      @(negedge clock);
      edges++;
    end
    check("b_reach_count5", count, 5);
    dividend = 32'hFFFF_FFFF; divisor = 16'h0002; start = 1'b1;
    @(negedge clock);
    edges++;
    start = 1'b0;
    while (!ready && edges < 64) begin
      @(negedge clock);
      edges++;
    end
    check("b_latency", edges, 34);
    check("b_result", {quotient, remainder, div_by_zero}, {32'h0000_000E, 16'h0002, 1'b0});

    // Reset mid-run aborts; a fresh operation then completes normally
    @(negedge clock);
    signed_mode = 1'b1; dividend = 32'hFFFF_FFF9; divisor = 16'h0002; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    edges = 1;
    while (count != 10 && edges < 64) begin
      @(negedge clock);
      edges++;
    end
    check("c_reach_count10", count, 10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("c_rst_outputs", {quotient, remainder, div_by_zero, busy, ready, count}, '0);
    check("c_rst_state", state_dbg, IDLE);
    run_op(1'b0, 32'h0000_0064, 16'h0007, edges);
    check("c_latency", edges, 34);
    check("c_result", {quotient, remainder}, {32'h0000_000E, 16'h0002});

    // start held high across the edge where ready rises
    @(negedge clock);
    signed_mode = 1'b0; dividend = 32'h0000_0064; divisor = 16'h0007; start = 1'b1;
    edges = 0;
    do begin
      @(negedge clock);
      edges++;
    end while (!ready && edges < 64);
    check("d_latency", edges, 34);
    check("d_first_result", {quotient, remainder}, {32'h0000_000E, 16'h0002});
    dividend = 32'h0000_000A; divisor = 16'h0003;
    @(negedge clock);
    start = 1'b0;
    check("d_reaccept", {busy, ready}, 2'b10);
    edges = 1;
    while (!ready && edges < 64) begin
      @(negedge clock);
      edges++;
    end
    check("d_second_latency", edges, 34);
    check("d_second_result", {quotient, remainder}, {32'h0000_0003, 16'h0001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
